// File: rtl/event_encoder8_3.sv
// Sequential 8-to-3 event encoder: captures request pulses into a pending set and
// hands out one fixed-priority index per captured event over a valid/ready port.
module event_encoder8_3 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic [7:0] req,
  output logic [2:0] out_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pending,
  output logic       ovf,
  output logic       idle
);

  logic [7:0] pending_q, pending_d;
  logic [2:0] out_code_q, out_code_d;
  logic       out_valid_q, out_valid_d;
  logic       ovf_q, ovf_d;

  logic       load;
  logic       have_pend;
  logic [2:0] sel;
  logic [7:0] clr_mask;
  logic [7:0] req_eff;
  logic [7:0] held_mask;

  // Later loop iterations overwrite earlier ones, so the scan direction sets the winner.
  function automatic logic [2:0] prio_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  always_comb begin
    load      = !out_valid_q || out_ready;
    have_pend = |pending_q;
    sel       = prio_idx(pending_q);
    clr_mask  = (load && have_pend) ? onehot(sel) : 8'h00;
    req_eff   = e ? 8'h00 : req;
    // A code sitting in the output and not taken this cycle still counts as outstanding.
    held_mask = (out_valid_q && !out_ready) ? onehot(out_code_q) : 8'h00;

    pending_d   = (pending_q & ~clr_mask) | req_eff;
    ovf_d       = ovf_q | (|(req_eff & ((pending_q & ~clr_mask) | held_mask)));
    out_valid_d = load ? have_pend : out_valid_q;
    out_code_d  = (load && have_pend) ? sel : out_code_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 8'h00;
      out_code_q  <= 3'd0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pending   = pending_q;
  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign idle      = (pending_q == 8'h00) && !out_valid_q;

endmodule

// File: tb/tb_event_encoder8_3.sv
// Directed bench for event_encoder8_3: two instances (MSB-first and LSB-first),
// expected codes queued at stimulus time and popped on each observed transfer.
module tb_event_encoder8_3;

  logic       clk = 1'b0;
  logic       rst, e, rdy;
  logic [7:0] req;
  logic [2:0] ca;
  logic       va, oa, ia;
  logic [7:0] pa;

  logic       e_b, rdy_b;
  logic [7:0] req_b;
  logic [2:0] cb;
  logic       vb, ob, ib;
  logic [7:0] pb;

  int n_vec = 0;
  int n_bad = 0;
  int qa[$];
  int qb[$];

  always #5 clk = ~clk;

  event_encoder8_3 #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .e(e), .req(req),
    .out_code(ca), .out_valid(va), .out_ready(rdy),
    .pending(pa), .ovf(oa), .idle(ia)
  );

  event_encoder8_3 #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .e(e_b), .req(req_b),
    .out_code(cb), .out_valid(vb), .out_ready(rdy_b),
    .pending(pb), .ovf(ob), .idle(ib)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; any transfer that happened on that edge is checked against the queue.
  task automatic step();
    logic       xa, xb;
    logic [2:0] code_a, code_b;
    xa = va && rdy;
    xb = vb && rdy_b;
    code_a = ca;
    code_b = cb;
    @(posedge clk);
    #1;
    if (xa) begin
      chk("A_xfer_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) chk("A_code", 32'(code_a), 32'(qa.pop_front()));
    end
    if (xb) begin
      chk("B_xfer_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) chk("B_code", 32'(code_b), 32'(qb.pop_front()));
    end
  endtask

  initial begin
    rst = 1'b1; e = 1'b1; req = 8'h00; rdy = 1'b0;
    e_b = 1'b0; req_b = 8'h00; rdy_b = 1'b1;
    step();
    step();
    chk("rst_pending", 32'(pa), 32'h00);
    chk("rst_valid", 32'(va), 32'd0);
    chk("rst_code", 32'(ca), 32'd0);
    chk("rst_ovf", 32'(oa), 32'd0);
    chk("rst_idle", 32'(ia), 32'd1);
    rst = 1'b0;

    // single event, two-edge latency
    e = 1'b0; req = 8'h10; rdy = 1'b1; qa.push_back(4);
    step();
    req = 8'h00;
    chk("t1_pending", 32'(pa), 32'h10);
    chk("t1_valid_early", 32'(va), 32'd0);
    step();
    chk("t1_valid", 32'(va), 32'd1);
    chk("t1_code", 32'(ca), 32'd4);
    step();
    chk("t1_idle", 32'(ia), 32'd1);
    chk("t1_pending_clr", 32'(pa), 32'h00);
    chk("t1_valid_done", 32'(va), 32'd0);

    // multi-bit, MSB first, back-to-back
    req = 8'hA5; qa.push_back(7); qa.push_back(5); qa.push_back(2); qa.push_back(0);
    step();
    req = 8'h00;
    chk("t2_pending", 32'(pa), 32'hA5);
    for (int i = 0; i < 5; i++) step();
    chk("t2_valid_done", 32'(va), 32'd0);
    chk("t2_ovf", 32'(oa), 32'd0);
    chk("t2_left", 32'(qa.size()), 32'd0);

    // multi-bit, LSB first
    req_b = 8'hA5; qb.push_back(0); qb.push_back(2); qb.push_back(5); qb.push_back(7);
    step();
    req_b = 8'h00;
    for (int i = 0; i < 5; i++) step();
    chk("t2b_valid_done", 32'(vb), 32'd0);
    chk("t2b_ovf", 32'(ob), 32'd0);
    chk("t2b_left", 32'(qb.size()), 32'd0);

    // backpressure holds output stable
    rdy = 1'b0; req = 8'h03; qa.push_back(1); qa.push_back(0);
    step();
    req = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", 32'(va), 32'd1);
      chk("t3_hold_code", 32'(ca), 32'd1);
      chk("t3_hold_pending", 32'(pa), 32'h01);
    end
    rdy = 1'b1;
    step();
    step();
    step();
    chk("t3_valid_done", 32'(va), 32'd0);
    chk("t3_ovf", 32'(oa), 32'd0);

    // re-request of the held code raises ovf and is emitted again
    rdy = 1'b0; req = 8'h08; qa.push_back(3);
    step();
    req = 8'h00;
    step();
    chk("t4_code", 32'(ca), 32'd3);
    chk("t4_ovf_pre", 32'(oa), 32'd0);
    req = 8'h08; qa.push_back(3);
    step();
    req = 8'h00;
    chk("t4_ovf", 32'(oa), 32'd1);
    chk("t4_pending", 32'(pa), 32'h08);
    chk("t4_valid", 32'(va), 32'd1);
    step();
    chk("t4_ovf_sticky", 32'(oa), 32'd1);
    rdy = 1'b1;
    step();
    step();
    chk("t4_valid_done", 32'(va), 32'd0);
    chk("t4_ovf_still", 32'(oa), 32'd1);

    // e=1 ignores requests
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_ovf_cleared", 32'(oa), 32'd0);
    e = 1'b1; req = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_pending", 32'(pa), 32'h00);
      chk("t5_valid", 32'(va), 32'd0);
      chk("t5_ovf", 32'(oa), 32'd0);
    end
    e = 1'b0; req = 8'h00;

    // reset during a stalled transfer discards the held event
    rdy = 1'b0; req = 8'h40;
    step();
    req = 8'h00;
    step();
    chk("t6_valid", 32'(va), 32'd1);
    chk("t6_code", 32'(ca), 32'd6);
    req = 8'h40;
    step();
    req = 8'h00;
    chk("t6_ovf", 32'(oa), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_valid", 32'(va), 32'd0);
    chk("t6_rst_pending", 32'(pa), 32'h00);
    chk("t6_rst_ovf", 32'(oa), 32'd0);
    chk("t6_rst_idle", 32'(ia), 32'd1);
    chk("t6_rst_code", 32'(ca), 32'd0);
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t6_no_emit", 32'(va), 32'd0);
    chk("end_qa_empty", 32'(qa.size()), 32'd0);
    chk("end_qb_empty", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/event_encoder8_3.md
Name: event_encoder8_3

Overview:
- Sequential 8-to-3 event encoder. It is the inverse of the team's 3-to-8 decoder.
- Captures requests on 8 event lines into a pending register.
- Emits the 3-bit index of one pending line at a time, by fixed priority, over a valid/ready handshake. Each index is emitted once per captured event.
- Sits between interrupt/event sources and a consumer (e.g. a 3-to-8 decoder driving acknowledge lines) that needs binary codes.

Parameters:
- MSB_FIRST, 1, priority order. 1: bit 7 is highest priority. 0: bit 0 is highest priority.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- e  input  1  active-low capture enable. 0 = capture requests; 1 = ignore new requests.
- req  input  8  event request lines. Sampled every cycle; a bit at 1 for one or more cycles is one event.
- out_code  output  3  binary index of the emitted event.
- out_valid  output  1  out_code holds an event.
- out_ready  input  1  consumer accepts out_code this cycle when out_valid=1.
- pending  output  8  current pending register, for debug/status.
- ovf  output  1  sticky flag: a request arrived on a line already pending or already held in the output.
- idle  output  1  pending==0 and out_valid==0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pending=0, out_valid=0, out_code=0, ovf=0, idle=1.
  - Reset overrides every other event in that cycle, including a handshake in progress. Any event held in the output is discarded.
- Capture, when e=0: pend_next = (pending & ~clr_mask) | req.
  - Set wins: if the bit being cleared this cycle is also requested, it stays pending.
- When e=1: req is ignored and pending only drains.
- Load condition: load = (out_valid==0) | (out_ready==1).
- Output register on load:
  - If the pending register (value before this edge) is non-zero: out_code <= index of highest-priority set bit, out_valid <= 1, and that bit goes into clr_mask.
  - Otherwise out_valid <= 0; out_code holds its last value.
- Latency:
  - req at edge N enters pending at edge N.
  - With the output free, out_valid=1 with the code after edge N+1, a 2-cycle minimum.
  - Back-to-back: with out_ready held at 1, one code per cycle.
- Handshake:
  - While out_valid=1 and out_ready=0, out_code and out_valid are held stable. Nothing is cleared from pending.
  - Transfer occurs on any edge with out_valid=1 and out_ready=1.
- Overflow: ovf <= 1 if e=0 and any requested bit satisfies either condition:
  - it is already set in pending and not cleared this cycle; or
  - out_valid=1 and it equals the held, unaccepted out_code.
  - The request is still merged. ovf is cleared only by rst.
- Priority:
  - Fixed, not round-robin. A continuously re-asserted high-priority line can starve lower lines; this is accepted behaviour.
- Multiple bits asserted in one cycle:
  - All are captured and emitted in priority order over successive transfers.
- Implementation:
  - Priority selection is combinational from pending.
  - All outputs are registered, except idle, which is derived from registers.

Test Plan:
- Reset, then e=0, req=8'h10 for 1 cycle, out_ready=1 -> out_valid=1, out_code=4 two edges after req. Then idle=1 and pending=0 one cycle later.
- MSB_FIRST=1, req=8'hA5 for 1 cycle, out_ready=1 -> codes 7,5,2,0 on consecutive cycles, then out_valid=0, ovf=0. Repeat with MSB_FIRST=0 -> codes 0,2,5,7.
- req=8'h03, out_ready=0 for 5 cycles -> out_code=1 held stable with out_valid=1 and pending=8'h01. Raise out_ready -> codes 1, then 0.
- Hold out_ready=0 with code 3 valid, pulse req=8'h08 -> ovf=1 (sticky). pending bit 3 set, so code 3 emits twice.
- e=1 with req=8'hFF for 4 cycles -> pending stays 0, out_valid=0, ovf=0.
- req=8'h40, then assert rst for 1 cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, pending=0, ovf=0, idle=1. No code 6 is emitted afterwards.
